// File: rtl/channel_noise.sv
// channel_noise: adds scaled sum-of-four-uniform LFSR noise to an I/Q stream.
// Two-stage pipeline: stage 1 captures data and scaled noise, stage 2 adds and saturates.
module channel_noise #(
    parameter int unsigned NBT_OUT = 8,
    parameter int unsigned NBF_OUT = 6,
    parameter logic [14:0] SEED_I  = 15'h2A5B,
    parameter logic [14:0] SEED_Q  = 15'h1C37
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic signed [NBT_OUT-1:0] i_data_I,
    input  logic signed [NBT_OUT-1:0] i_data_Q,
    input  logic                      i_valid,
    input  logic                      i_noise_en,
    input  logic [2:0]                i_noise_shift,
    output logic signed [NBT_OUT-1:0] o_data_I,
    output logic signed [NBT_OUT-1:0] o_data_Q,
    output logic                      o_valid
);

    localparam int unsigned LW = 15;   // LFSR width
    localparam int unsigned NL = 4;    // LFSRs per branch
    localparam int unsigned NB = 2;    // branches: 0 = I, 1 = Q
    localparam int unsigned UW = 8;    // uniform sample width
    localparam int unsigned NW = 10;   // branch noise width
    localparam int unsigned SW = ((NBT_OUT > NW) ? NBT_OUT : NW) + 1;

    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (NBT_OUT - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic [NB-1:0][LW-1:0] SEED_BASE = {SEED_Q, SEED_I};

    // Data and noise share the same LSB weight, so the fractional width only constrains the format.
    if (NBF_OUT >= NBT_OUT) begin : g_bad_format
    end

    // Per-LFSR seed: base xor k*0x1357, never all-zero.
    function automatic logic [LW-1:0] lfsr_seed(input logic [LW-1:0] base, input int unsigned k);
        logic [LW-1:0] s;
        s = base ^ LW'(k * 32'h1357);
        if (s == '0) begin
            s = LW'(1);
        end
        return s;
    endfunction

    logic [NB-1:0][NL-1:0][LW-1:0] lfsr_q, lfsr_d;
    logic [NB-1:0][NW-1:0]         noise_scl_c;
    logic [NB-1:0][NBT_OUT-1:0]    s1_data_q, s1_data_d;
    logic [NB-1:0][NW-1:0]         s1_noise_q, s1_noise_d;
    logic                          s1_valid_q;
    logic [NB-1:0][NBT_OUT-1:0]    out_data_q, out_data_d;
    logic                          out_valid_q;

    // LFSR advance on valid samples and branch noise from the pre-advance state.
    always_comb begin
        logic signed [NW-1:0] acc;
        lfsr_d      = lfsr_q;
        noise_scl_c = '0;
        acc         = '0;
        for (int b = 0; b < NB; b++) begin
            acc = '0;
            for (int k = 0; k < NL; k++) begin
                acc = acc + {{(NW-UW){lfsr_q[b][k][LW-1]}}, lfsr_q[b][k][LW-1 -: UW]};
                if (i_valid) begin
                    lfsr_d[b][k] = {lfsr_q[b][k][LW-2:0], lfsr_q[b][k][LW-1] ^ lfsr_q[b][k][LW-2]};
                end
            end
            noise_scl_c[b] = acc >>> i_noise_shift;
        end
    end

    // Stage 1 capture: data plus scaled (or zeroed) noise on each valid sample.
    always_comb begin
        s1_data_d  = s1_data_q;
        s1_noise_d = s1_noise_q;
        if (i_valid) begin
            s1_data_d[0] = i_data_I;
            s1_data_d[1] = i_data_Q;
            for (int b = 0; b < NB; b++) begin
                s1_noise_d[b] = i_noise_en ? noise_scl_c[b] : '0;
            end
        end
    end

    // Stage 2: widened add and saturation to the output range.
    always_comb begin
        logic signed [SW-1:0] sum;
        logic signed [SW-1:0] clip;
        out_data_d = out_data_q;
        sum        = '0;
        clip       = '0;
        for (int b = 0; b < NB; b++) begin
            sum = {{(SW-NBT_OUT){s1_data_q[b][NBT_OUT-1]}}, s1_data_q[b]}
                + {{(SW-NW){s1_noise_q[b][NW-1]}}, s1_noise_q[b]};
            if (sum > SAT_MAX) begin
                clip = SAT_MAX;
            end else if (sum < SAT_MIN) begin
                clip = SAT_MIN;
            end else begin
                clip = sum;
            end
            if (s1_valid_q) begin
                out_data_d[b] = clip[NBT_OUT-1:0];
            end
        end
    end

    // LFSR bank state; reset reloads the seeds.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int b = 0; b < NB; b++) begin
                for (int unsigned k = 0; k < NL; k++) begin
                    lfsr_q[b][k] <= lfsr_seed(SEED_BASE[b], k);
                end
            end
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Pipeline registers; reset discards any in-flight sample.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            s1_data_q   <= '0;
            s1_noise_q  <= '0;
            s1_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_data_q   <= s1_data_d;
            s1_noise_q  <= s1_noise_d;
            s1_valid_q  <= i_valid;
            out_data_q  <= out_data_d;
            out_valid_q <= s1_valid_q;
        end
    end

    assign o_data_I = out_data_q[0];
    assign o_data_Q = out_data_q[1];
    assign o_valid  = out_valid_q;

endmodule

// File: tb/tb_channel_noise.sv
// Testbench for channel_noise: hand-computed vectors plus a sample-level reference model.
module tb_channel_noise;

    localparam int NBT = 8;

    logic                  clk = 1'b0;
    logic                  i_reset;
    logic signed [NBT-1:0] i_data_I;
    logic signed [NBT-1:0] i_data_Q;
    logic                  i_valid;
    logic                  i_noise_en;
    logic [2:0]            i_noise_shift;
    logic signed [NBT-1:0] o_data_I;
    logic signed [NBT-1:0] o_data_Q;
    logic                  o_valid;

    channel_noise dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_data_I     (i_data_I),
        .i_data_Q     (i_data_Q),
        .i_valid      (i_valid),
        .i_noise_en   (i_noise_en),
        .i_noise_shift(i_noise_shift),
        .o_data_I     (o_data_I),
        .o_data_Q     (o_data_Q),
        .o_valid      (o_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
    } exp_t;

    typedef struct {
        bit en;
        int sh;
        int di;
        int dq;
        int ei;
        int eq;
    } vec_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned lfsr_m [2][4];
    exp_t        expq [$];
    exp_t        last_e;
    bit          prev_v;
    vec_t        tbl [8];
    int          pat_di [24];
    int          pat_dq [24];
    bit          pat_v  [24];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    function automatic void model_reset();
        int unsigned base;
        for (int b = 0; b < 2; b++) begin
            base = (b == 0) ? 32'h2A5B : 32'h1C37;
            for (int k = 0; k < 4; k++) begin
                lfsr_m[b][k] = (base ^ (k * 32'h1357)) & 32'h7FFF;
                if (lfsr_m[b][k] == 0) lfsr_m[b][k] = 1;
            end
        end
    endfunction

    function automatic int model_noise(input int b, input int sh);
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            int u;
            u = int'((lfsr_m[b][k] >> 7) & 32'hFF);
            if (u >= 128) u = u - 256;
            n = n + u;
        end
        return n >>> sh;
    endfunction

    function automatic void model_advance();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                lfsr_m[b][k] = ((lfsr_m[b][k] << 1) & 32'h7FFF)
                             | (((lfsr_m[b][k] >> 14) ^ (lfsr_m[b][k] >> 13)) & 1);
            end
        end
    endfunction

    // One clock: drive at negedge, check outputs just after the following posedge.
    task automatic tick(input bit v, input int di, input int dq, input bit en, input int sh);
        exp_t e;
        @(negedge clk);
        i_valid       = v;
        i_data_I      = NBT'(di);
        i_data_Q      = NBT'(dq);
        i_noise_en    = en;
        i_noise_shift = 3'(sh);
        if (v) begin
            e.i = sat(di + (en ? model_noise(0, sh) : 0));
            e.q = sat(dq + (en ? model_noise(1, sh) : 0));
            expq.push_back(e);
            model_advance();
        end
        @(posedge clk);
        #1;
        if (prev_v && expq.size() > 0) last_e = expq.pop_front();
        check("o_valid", int'(o_valid), int'(prev_v));
        check("o_data_I", int'(o_data_I), last_e.i);
        check("o_data_Q", int'(o_data_Q), last_e.q);
        prev_v = v;
    endtask

    // Asynchronous reset pulse mid-cycle; inputs are left as they are.
    task automatic do_reset();
        @(negedge clk);
        #2;
        i_reset = 1'b0;
        #1;
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_data_I", int'(o_data_I), 0);
        check("rst_o_data_Q", int'(o_data_Q), 0);
        @(posedge clk);
        #2;
        i_reset = 1'b1;
        model_reset();
        expq.delete();
        prev_v   = 1'b0;
        last_e.i = 0;
        last_e.q = 0;
    endtask

    task automatic run_pattern(input int len);
        for (int i = 0; i < len; i++) begin
            tick(pat_v[i], pat_di[i], pat_dq[i], 1'b1, 2);
        end
    endtask

    initial begin
        int mn;
        int mx;
        i_reset       = 1'b0;
        i_valid       = 1'b0;
        i_data_I      = '0;
        i_data_Q      = '0;
        i_noise_en    = 1'b0;
        i_noise_shift = '0;
        prev_v        = 1'b0;
        last_e.i      = 0;
        last_e.q      = 0;

        // First-sample noise from the seed state: I = 255, Q = 279 before shifting.
        tbl[0] = '{1'b0, 0,   40,  -17,   40,  -17};
        tbl[1] = '{1'b1, 0,    0,    0,  127,  127};
        tbl[2] = '{1'b1, 3,   40,  -17,   71,   17};
        tbl[3] = '{1'b1, 7,  127, -128,  127, -126};
        tbl[4] = '{1'b1, 1, -128, -128,   -1,   11};
        tbl[5] = '{1'b1, 4,  100,  120,  115,  127};
        tbl[6] = '{1'b0, 5, -128,  127, -128,  127};
        tbl[7] = '{1'b1, 2, -100,  -50,  -37,   19};

        for (int i = 0; i < 24; i++) begin
            pat_v[i]  = ($urandom_range(0, 3) != 0);
            pat_di[i] = int'($urandom_range(0, 255)) - 128;
            pat_dq[i] = int'($urandom_range(0, 255)) - 128;
        end

        model_reset();
        @(posedge clk);
        #2;
        check("init_o_valid", int'(o_valid), 0);
        check("init_o_data_I", int'(o_data_I), 0);
        check("init_o_data_Q", int'(o_data_Q), 0);
        @(negedge clk);
        #2;
        i_reset = 1'b1;

        // Single sample after a fresh reset against hand-computed results.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            tick(1'b1, tbl[i].di, tbl[i].dq, tbl[i].en, tbl[i].sh);
            tick(1'b0, 0, 0, tbl[i].en, tbl[i].sh);
            check($sformatf("tbl%0d_valid", i), int'(o_valid), 1);
            check($sformatf("tbl%0d_I", i), int'(o_data_I), tbl[i].ei);
            check($sformatf("tbl%0d_Q", i), int'(o_data_Q), tbl[i].eq);
            tick(1'b0, 0, 0, 1'b0, 0);
            check($sformatf("tbl%0d_hold_I", i), int'(o_data_I), tbl[i].ei);
        end

        // Shift changes 2 -> 5 between consecutive samples.
        do_reset();
        tick(1'b1, 0, 0, 1'b1, 2);
        tick(1'b1, 0, 0, 1'b1, 5);
        check("sh2_I", int'(o_data_I), 63);
        check("sh2_Q", int'(o_data_Q), 69);
        tick(1'b0, 0, 0, 1'b1, 2);
        check("sh5_I", int'(o_data_I), 0);
        check("sh5_Q", int'(o_data_Q), 1);

        // Bypass: constant stream passes through unchanged.
        do_reset();
        for (int i = 0; i < 20; i++) tick(1'b1, 40, -17, 1'b0, 0);
        check("byp_I", int'(o_data_I), 40);
        check("byp_Q", int'(o_data_Q), -17);
        check("byp_valid", int'(o_valid), 1);

        // Full-scale inputs with unattenuated noise.
        for (int i = 0; i < 2000; i++) tick(1'b1, 127, 127, 1'b1, 0);
        for (int i = 0; i < 2000; i++) tick(1'b1, -128, -128, 1'b1, 0);

        // Valid gap mid-stream: LFSRs hold, stream resumes in step.
        do_reset();
        for (int i = 0; i < 30; i++) tick(1'b1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b1, 1);
        for (int i = 0; i < 5; i++) tick(1'b0, 0, 0, 1'b1, 1);
        for (int i = 0; i < 30; i++) tick(1'b1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1'b1, 1);

        // Random valid, enable, shift and data.
        for (int i = 0; i < 400; i++) begin
            tick(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end

        // Reset while valid is high, then the same pattern replayed from the seeds.
        do_reset();
        run_pattern(24);
        run_pattern(10);
        tick(1'b1, 5, 5, 1'b1, 2);
        do_reset();
        run_pattern(24);

        // Zero input, shift 3: output bounded by the scaled noise range.
        do_reset();
        mn = 1000;
        mx = -1000;
        for (int i = 0; i < 8192; i++) begin
            tick(1'b1, 0, 0, 1'b1, 3);
            if (int'(o_data_I) < mn) mn = int'(o_data_I);
            if (int'(o_data_Q) < mn) mn = int'(o_data_Q);
            if (int'(o_data_I) > mx) mx = int'(o_data_I);
            if (int'(o_data_Q) > mx) mx = int'(o_data_Q);
        end
        check("zero_min_ge_-64", int'(mn >= -64), 1);
        check("zero_max_le_63", int'(mx <= 63), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
